// File: rtl/layer_sequencer.sv
// layer_sequencer: launches the CNN layer engines one after another, waits
// for each engine's done pulse, guards every stage with a watchdog and
// reports frame completion, faults and the total frame latency.
module layer_sequencer #(
  parameter  int NUM_STAGES     = 4,
  parameter  int TIMEOUT_CYCLES = 1_000_000,
  parameter  int CYC_W          = 32,
  localparam int IDX_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_stage,
  output logic [CYC_W-1:0]      cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FINISH,
    S_FAULT
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t                  r_state,       w_state_nxt;
  logic [IDX_W-1:0]        r_idx,         w_idx_nxt;
  logic [TMR_W-1:0]        r_timer,       w_timer_nxt;
  logic [CYC_W-1:0]        r_run,         w_run_nxt;
  logic [NUM_STAGES-1:0]   r_stage_start, w_stage_start_nxt;
  logic                    r_busy,        w_busy_nxt;
  logic                    r_done,        w_done_nxt;
  logic                    r_error,       w_error_nxt;
  logic [IDX_W-1:0]        r_err_stage,   w_err_stage_nxt;
  logic [CYC_W-1:0]        r_cycle_count, w_cycle_count_nxt;

  logic                    w_done_sel;
  logic [IDX_W-1:0]        w_idx_inc;
  logic [CYC_W-1:0]        w_run_inc;

  assign w_idx_inc = r_idx + 1'b1;
  assign w_run_inc = (r_run == '1) ? r_run : r_run + 1'b1;

  // Select the done bit of the active stage; all other done bits are ignored.
  always_comb begin
    w_done_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (r_idx == IDX_W'(i)) w_done_sel = stage_done[i];
    end
  end

  // Next-state and registered-output logic; abort beats done, done beats timeout.
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_timer_nxt       = r_timer;
    w_run_nxt         = r_run;
    w_stage_start_nxt = '0;
    w_busy_nxt        = r_busy;
    w_done_nxt        = 1'b0;
    w_error_nxt       = 1'b0;
    w_err_stage_nxt   = r_err_stage;
    w_cycle_count_nxt = r_cycle_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_stage_start_nxt[0] = 1'b1;
          w_idx_nxt            = '0;
          w_timer_nxt          = '0;
          w_run_nxt            = '0;
          w_busy_nxt           = 1'b1;
          w_state_nxt          = S_WAIT;
        end
      end
      S_WAIT: begin
        w_run_nxt   = w_run_inc;
        w_timer_nxt = r_timer + 1'b1;
        if (abort) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_done_sel) begin
          if (r_idx != LAST_IDX) begin
            w_idx_nxt   = w_idx_inc;
            w_timer_nxt = '0;
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
              if (IDX_W'(i) == w_idx_inc) w_stage_start_nxt[i] = 1'b1;
            end
          end else begin
            // running counter lags by one; the saturating increment counts the done cycle
            w_cycle_count_nxt = w_run_inc;
            w_state_nxt       = S_FINISH;
          end
        end else if (r_timer == TMR_LIMIT) begin
          w_err_stage_nxt = r_idx;
          w_state_nxt     = S_FAULT;
        end
      end
      S_FINISH: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        w_error_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_timer       <= '0;
      r_run         <= '0;
      r_stage_start <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_err_stage   <= '0;
      r_cycle_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_timer       <= w_timer_nxt;
      r_run         <= w_run_nxt;
      r_stage_start <= w_stage_start_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_error       <= w_error_nxt;
      r_err_stage   <= w_err_stage_nxt;
      r_cycle_count <= w_cycle_count_nxt;
    end
  end

  assign stage_start = r_stage_start;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign err_stage   = r_err_stage;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: three configurations (4 stages, 2 stages,
// 1 stage with a 3-bit latency counter) driven one at a time. Each frame is
// described by per-stage durations; the expected event timeline is derived
// arithmetically from those durations and compared cycle by cycle.
module tb_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort;
  logic [3:0] sd;
  int         sel;

  logic       start_a, start_b, start_c, abort_a, abort_b, abort_c;
  logic [3:0] sd_a;
  logic [1:0] sd_b;
  logic [0:0] sd_c;
  logic [3:0] ss_a;
  logic [1:0] ss_b;
  logic [0:0] ss_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c, err_a, err_b, err_c;
  logic [1:0] es_a;
  logic [0:0] es_b, es_c;
  logic [31:0] cc_a, cc_b;
  logic [2:0] cc_c;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);
  assign abort_a = abort && (sel == 0);
  assign abort_b = abort && (sel == 1);
  assign abort_c = abort && (sel == 2);
  assign sd_a    = (sel == 0) ? sd      : 4'b0;
  assign sd_b    = (sel == 1) ? sd[1:0] : 2'b0;
  assign sd_c    = (sel == 2) ? sd[0:0] : 1'b0;

  layer_sequencer #(.NUM_STAGES(4), .TIMEOUT_CYCLES(16), .CYC_W(32)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .stage_start(ss_a), .stage_done(sd_a), .busy(busy_a), .done(done_a),
    .error(err_a), .err_stage(es_a), .cycle_count(cc_a));

  layer_sequencer #(.NUM_STAGES(2), .TIMEOUT_CYCLES(16), .CYC_W(32)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .stage_start(ss_b), .stage_done(sd_b), .busy(busy_b), .done(done_b),
    .error(err_b), .err_stage(es_b), .cycle_count(cc_b));

  layer_sequencer #(.NUM_STAGES(1), .TIMEOUT_CYCLES(16), .CYC_W(3)) u_dut_c (
    .clk(clk), .reset(reset), .start(start_c), .abort(abort_c),
    .stage_start(ss_c), .stage_done(sd_c), .busy(busy_c), .done(done_c),
    .error(err_c), .err_stage(es_c), .cycle_count(cc_c));

  // Observed outputs of the currently selected configuration.
  logic [3:0]  o_ss;
  logic        o_busy, o_done, o_err;
  logic [1:0]  o_es;
  logic [31:0] o_cc;
  always_comb begin
    o_ss = ss_a; o_busy = busy_a; o_done = done_a; o_err = err_a; o_es = es_a; o_cc = cc_a;
    if (sel == 1) begin
      o_ss = {2'b00, ss_b}; o_busy = busy_b; o_done = done_b; o_err = err_b;
      o_es = {1'b0, es_b};  o_cc = cc_b;
    end else if (sel == 2) begin
      o_ss = {3'b000, ss_c}; o_busy = busy_c; o_done = done_c; o_err = err_c;
      o_es = {1'b0, es_c};   o_cc = {29'd0, cc_c};
    end
  end

  int NS[3] = '{4, 2, 1};
  int TO[3] = '{16, 16, 16};
  int CW[3] = '{32, 32, 3};

  logic [31:0] exp_cc[3];
  logic [31:0] exp_es[3];
  int          dur[4];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, cfg=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, " stage_start"}, {28'd0, o_ss}, 32'd0);
    check_eq({tag, " busy"},        {31'd0, o_busy}, 32'd0);
    check_eq({tag, " done"},        {31'd0, o_done}, 32'd0);
    check_eq({tag, " error"},       {31'd0, o_err}, 32'd0);
    check_eq({tag, " err_stage"},   {30'd0, o_es}, 32'd0);
    check_eq({tag, " cycle_count"}, o_cc, 32'd0);
  endtask

  // One frame on configuration s using dur[]: dur[i] = WAIT cycle of stage i
  // on which its done arrives, 0 = never. a = abort cycle (0 = none).
  // Called at a negedge in an IDLE cycle ("cycle 0"); returns at the negedge
  // of the first IDLE cycle after the frame, with that cycle's inputs set.
  task automatic run_frame(input int s, input int a, input bit hold, input bit noise);
    int n, t, endw, tj, nl, kind, L, busy_end, last_wait, cur;
    int b[4];
    logic [31:0] ccmax, exp_ss;
    n = NS[s]; t = TO[s];
    ccmax = (CW[s] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CW[s]) - 32'd1);
    for (int i = 0; i < 4; i++) b[i] = 1 << 20;
    b[0] = 1; tj = -1; nl = n; endw = 0;
    for (int i = 0; i < n; i++) begin
      if (tj < 0) begin
        if (dur[i] == 0) begin
          tj = i; endw = b[i] + t - 1; nl = i + 1;
        end else if (i == n - 1) endw = b[i] + dur[i] - 1;
        else b[i+1] = b[i] + dur[i];
      end
    end
    if (a >= 1 && a <= endw) begin
      kind = 2; L = a + 1; busy_end = a; last_wait = a;
      for (int i = 0; i < 4; i++) if (i < nl && b[i] > a) nl = i;
    end else begin
      kind = (tj >= 0) ? 1 : 0; L = endw + 2; busy_end = endw + 1; last_wait = endw;
    end

    sel = s; start = 1'b1;
    abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    sd = noise ? 4'($urandom_range(0, 15)) : 4'b0;
    for (int c = 1; c <= L; c++) begin
      @(negedge clk);
      if (kind == 0 && c == endw + 1) exp_cc[s] = (32'(endw) > ccmax) ? ccmax : 32'(endw);
      if (kind == 1 && c == endw + 1) exp_es[s] = 32'(tj);
      exp_ss = 32'd0;
      for (int i = 0; i < 4; i++) if (i < nl && b[i] == c) exp_ss[i] = 1'b1;
      check_eq($sformatf("stage_start c%0d", c), {28'd0, o_ss}, exp_ss);
      check_eq($sformatf("busy c%0d", c),  {31'd0, o_busy}, {31'd0, c <= busy_end});
      check_eq($sformatf("done c%0d", c),  {31'd0, o_done}, {31'd0, kind == 0 && c == endw + 2});
      check_eq($sformatf("error c%0d", c), {31'd0, o_err},  {31'd0, kind == 1 && c == endw + 2});
      check_eq($sformatf("err_stage c%0d", c),   {30'd0, o_es}, exp_es[s]);
      check_eq($sformatf("cycle_count c%0d", c), o_cc, exp_cc[s]);
      start = hold;
      if (c <= last_wait) begin
        cur = 0;
        for (int i = 0; i < 4; i++) if (i < nl && b[i] <= c) cur = i;
        sd = noise ? 4'($urandom_range(0, 15)) : 4'b0;
        sd[cur] = (dur[cur] != 0) && (c == b[cur] + dur[cur] - 1);
        abort = (kind == 2) && (c == a);
      end else begin
        sd = noise ? 4'($urandom_range(0, 15)) : 4'b0;
        abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  endtask

  // Reset while stage 0 completes: the stage_start[1] launch must be dropped.
  task automatic reset_mid_frame();
    sel = 0; start = 1'b1; abort = 1'b0; sd = 4'b0;
    @(negedge clk);
    start = 1'b0; sd = 4'b0001; reset = 1'b1;
    @(negedge clk);
    check_cleared("reset_mid");
    reset = 1'b0; sd = 4'b0;
    for (int i = 0; i < 3; i++) begin exp_cc[i] = 32'd0; exp_es[i] = 32'd0; end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; sd = 4'b0; sel = 0;
    for (int i = 0; i < 3; i++) begin exp_cc[i] = 32'd0; exp_es[i] = 32'd0; end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check_cleared($sformatf("reset cfg%0d", s));
    end
    sel = 0;
    reset = 1'b0;
    @(negedge clk);

    // normal 2-stage frame: 5 + 3 WAIT cycles
    dur = '{5, 3, 0, 0};
    run_frame(1, 0, 1'b0, 1'b0);
    check_eq("normal cycle_count", o_cc, 32'd8);

    // stage 2 hangs, then a new frame is accepted in the first IDLE cycle
    dur = '{3, 4, 0, 1};
    run_frame(0, 0, 1'b0, 1'b0);
    check_eq("timeout err_stage", {30'd0, o_es}, 32'd2);
    dur = '{2, 2, 2, 2};
    run_frame(0, 0, 1'b0, 1'b0);

    // done exactly on the last allowed WAIT cycle wins over the watchdog
    dur = '{16, 1, 1, 1};
    run_frame(0, 0, 1'b0, 1'b0);

    // spurious done bits on inactive stages plus ignored start/abort
    dur = '{6, 2, 2, 2};
    run_frame(0, 0, 1'b0, 1'b1);

    // start held across a frame: exactly one frame, next begins right after done
    dur = '{2, 3, 1, 2};
    run_frame(0, 0, 1'b1, 1'b0);
    dur = '{1, 1, 1, 1};
    run_frame(0, 0, 1'b0, 1'b0);

    // abort coincides with stage 1 done (cycle 6): no launch of stage 2
    dur = '{2, 4, 3, 3};
    run_frame(0, 6, 1'b0, 1'b0);

    reset_mid_frame();

    // single stage with a 3-bit latency counter
    dur = '{10, 0, 0, 0};
    run_frame(2, 0, 1'b0, 1'b0);
    check_eq("saturated cycle_count", o_cc, 32'd7);
    dur = '{5, 0, 0, 0};
    run_frame(2, 0, 1'b0, 1'b1);
    dur = '{0, 0, 0, 0};
    run_frame(2, 0, 1'b0, 1'b0);

    // randomized frames across all configurations
    for (int f = 0; f < 60; f++) begin
      for (int i = 0; i < 4; i++)
        dur[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 16));
      run_frame(int'($urandom_range(0, 2)),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 40)) : 0,
                1'($urandom_range(0, 3) == 0), 1'b1);
    end

    start = 1'b0; abort = 1'b0; sd = 4'b0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Top-level inference controller for the CNN pipeline. On `start`, it launches each layer engine in fixed order (conv, maxpool, dense, argmax, ...) with a one-cycle start pulse, and waits for that stage's one-cycle done pulse before launching the next. It guards every stage with a watchdog timeout and reports frame completion, a fault with the failing stage index, and the total frame latency in cycles.

## Interface
Parameters:
- `NUM_STAGES`, default 4: number of sequenced engines; stage 0 is launched first. Legal range is ≥1.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum WAIT cycles allowed per stage. Legal range is ≥2.
- `CYC_W`, default 32: width of the frame-latency counter.
- Derived `IDX_W` = max(1, $clog2(NUM_STAGES)).
- Derived `TMR_W` = $clog2(TIMEOUT_CYCLES+1).

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: frame request, sampled only in IDLE.
- `abort`, in, 1: cancels the frame in progress.
- `stage_start`, out, NUM_STAGES: one-hot, one-cycle launch pulse per stage.
- `stage_done`, in, NUM_STAGES: per-stage completion pulses.
- `busy`, out, 1: high while a frame is in flight.
- `done`, out, 1: one-cycle pulse when the frame completes.
- `error`, out, 1: one-cycle pulse on a watchdog timeout.
- `err_stage`, out, IDX_W: index of the timed-out stage; held until the next fault or reset.
- `cycle_count`, out, CYC_W: latency of the last completed frame; held until the next completion or reset.

## Operation
- States: IDLE, WAIT, FINISH, FAULT.
- All outputs are registered.
- Reset values: state=IDLE, `stage_start`=0, `busy`=0, `done`=0, `error`=0, `err_stage`=0, `cycle_count`=0. Internal stage index, timer and running counter are also 0.
- IDLE:
  - `start`=1 at an edge → `stage_start[0]`<=1, idx<=0, timer<=0, running counter<=0, `busy`<=1, state<=WAIT.
  - `start` while not IDLE is ignored and not queued.
- WAIT, every cycle:
  - `stage_start`<=0 unless relaunching.
  - Running counter increments, saturating at all-ones.
  - timer increments.
- WAIT, `stage_done[idx]`=1:
  - If idx<NUM_STAGES-1: idx<=idx+1, `stage_start[idx+1]`<=1, timer<=0, stay in WAIT.
  - If idx=NUM_STAGES-1: `cycle_count`<=running counter+1 (saturating, so the done cycle is included), state<=FINISH.
  - A done is accepted in any WAIT cycle, including the cycle in which that stage's `stage_start` is high.
- `stage_done` bits for any stage ≠ idx are ignored in every state.
- Timeout: WAIT with timer=TIMEOUT_CYCLES-1 and `stage_done[idx]`=0 → `err_stage`<=idx, state<=FAULT.
  - Done and the timeout limit in the same cycle: done wins.
- FINISH: `done`<=1 for one cycle, `busy`<=0, state<=IDLE.
- FAULT: `error`<=1 for one cycle, `busy`<=0, state<=IDLE. `cycle_count` is unchanged.
- `abort`=1 in WAIT: state<=IDLE, `busy`<=0, `stage_start`<=0. No `done`, no `error`, `cycle_count` unchanged.
  - `abort` has priority over done and timeout in the same cycle.
  - `abort` in IDLE, FINISH or FAULT has no effect.
- `reset` mid-frame: all state returns to reset values at the next edge. Any `stage_start` pulse is dropped.

## Timing
- `start` sampled at edge k → `stage_start[0]` high during cycle k..k+1; `busy` rises in the same cycle.
- `stage_done[i]` sampled at edge m → `stage_start[i+1]` high during cycle m..m+1. Inter-stage gap is 1 cycle.
- Final `stage_done` at edge m → `done` high during cycle m+1..m+2; `busy` low from edge m+2.
- Back-to-back frames: `start` is accepted at the earliest at the edge where `done` falls, i.e. the first IDLE cycle.
- `cycle_count` equals the number of WAIT cycles in the frame (the first `stage_start` cycle counts as 1).
- Timeout occurs on the TIMEOUT_CYCLES-th WAIT cycle of a stage; `error` follows one cycle later.

## Test plan
- Reset values and normal frame (NUM_STAGES=2, TIMEOUT_CYCLES=16):
  - Stage 0 done on its 5th WAIT cycle, stage 1 done on its 3rd.
  - Required: `stage_start` = 01 then 10, exactly 1 cycle each; `done` single pulse; `cycle_count`=8; `busy` high for 8 WAIT cycles + 1 FINISH cycle.
- Timeout (TIMEOUT_CYCLES=16, NUM_STAGES=4):
  - Stage 2 never completes.
  - Required: `error` pulses on the 17th cycle after `stage_start[2]`; `err_stage`=2; no `done`; `cycle_count` keeps its previous value; `start` accepted the next cycle.
- Done/timeout race: stage 0 done on exactly the 16th WAIT cycle → `stage_start[1]` pulses, no `error`.
- Spurious and ignored inputs:
  - `stage_done[3]` pulsed while idx=0 → ignored.
  - `start` held high during the whole frame → exactly one frame runs, then a second frame starts immediately after `done` falls.
- Abort and reset mid-frame:
  - `abort` asserted in the same cycle as `stage_done[1]` → IDLE, no `stage_start[2]`, no `done`/`error`.
  - `reset` during WAIT → all outputs 0 the next cycle.
- Degenerate and saturation cases:
  - NUM_STAGES=1 → `err_stage` is 1 bit wide; the frame completes normally.
  - CYC_W=3 with a 10-cycle frame → `cycle_count`=7 (saturated).
